alu_reservation_station: RTL and testbench

Reservation station feeding the combinational ArithmeticExecuteUnit. It holds dispatched ALU micro-ops until their A, B and NZCV source operands are available, captures operands from the common data bus (CDB), and issues one ready micro-op per cycle through a registered issue stage. Upstream is the dispatch/rename stage. Downstream is the ALU, whose result drives the CDB.

---
 rtl/alu_reservation_station_pkg.sv | 46 ++++
 rtl/alu_reservation_station_if.sv | 56 +++++
 rtl/rs_find_first.sv | 20 ++
 rtl/alu_reservation_station.sv | 148 ++++++++++++++
 tb/tb_alu_reservation_station.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_reservation_station_pkg.sv
// rtl/alu_reservation_station_pkg.sv - shared types for the ALU reservation station
package alu_reservation_station_pkg;

    localparam int GPR_SIZE = 64;
    localparam int RS_TAG_W = 4;

    typedef enum logic [3:0] {
        ALU_OP_PLUS, ALU_OP_MINUS, ALU_OP_AND, ALU_OP_ORR, ALU_OP_EOR,
        ALU_OP_MOV, ALU_OP_CSEL, ALU_OP_CSINC, ALU_OP_PASS
    } alu_op_t;

    typedef enum logic [3:0] {
        COND_EQ, COND_NE, COND_CS, COND_CC, COND_MI, COND_PL, COND_VS, COND_VC,
        COND_HI, COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_AL, COND_NV
    } cond_t;

    typedef logic [3:0]          nzcv_t;
    typedef logic [RS_TAG_W-1:0] rs_tag_t;

    typedef enum logic [1:0] {RS_FREE = 2'd0, RS_WAIT, RS_READY} rs_state_t;

    typedef struct packed {
        rs_state_t           state;
        alu_op_t             op;
        logic [5:0]          val_hw;
        logic                set_cc;
        cond_t               cond;
        logic [GPR_SIZE-1:0] val_a;
        rs_tag_t             tag_a;
        logic                rdy_a;
        logic [GPR_SIZE-1:0] val_b;
        rs_tag_t             tag_b;
        logic                rdy_b;
        nzcv_t               nzcv;
        rs_tag_t             nzcv_tag;
        logic                nzcv_rdy;
        rs_tag_t             dst_tag;
    } rs_entry_t;

    // True when a still-pending operand is produced by the current broadcast.
    function automatic logic cdb_hit(input logic cdb_valid, input logic rdy,
                                     input rs_tag_t tag, input rs_tag_t cdb_tag);
        return cdb_valid & ~rdy & (tag == cdb_tag);
    endfunction

endpackage

// File: rtl/alu_reservation_station_if.sv
// rtl/alu_reservation_station_if.sv - dispatch, CDB and issue signals of the reservation station
interface alu_reservation_station_if import alu_reservation_station_pkg::*; #(
    parameter int TAG_W = RS_TAG_W
);
    logic                in_flush;
    logic                in_dispatch_valid;
    logic                out_dispatch_ready;
    alu_op_t             in_alu_op;
    logic [GPR_SIZE-1:0] in_val_a;
    logic [GPR_SIZE-1:0] in_val_b;
    logic [TAG_W-1:0]    in_tag_a;
    logic [TAG_W-1:0]    in_tag_b;
    logic                in_ready_a;
    logic                in_ready_b;
    logic [5:0]          in_alu_val_hw;
    logic                in_set_CC;
    cond_t               in_cond;
    nzcv_t               in_nzcv;
    logic [TAG_W-1:0]    in_nzcv_tag;
    logic                in_nzcv_ready;
    logic [TAG_W-1:0]    in_dst_tag;
    logic                in_cdb_valid;
    logic [TAG_W-1:0]    in_cdb_tag;
    logic [GPR_SIZE-1:0] in_cdb_value;
    logic                in_cdb_set_nzcv;
    nzcv_t               in_cdb_nzcv;
    logic                out_issue_valid;
    logic                in_fu_ready;
    alu_op_t             out_alu_op;
    logic [GPR_SIZE-1:0] out_val_a;
    logic [GPR_SIZE-1:0] out_val_b;
    logic [5:0]          out_alu_val_hw;
    logic                out_set_CC;
    cond_t               out_cond;
    nzcv_t               out_prev_nzcv;
    logic [TAG_W-1:0]    out_dst_tag;

    modport master (
        output in_flush, in_dispatch_valid, in_alu_op, in_val_a, in_val_b, in_tag_a, in_tag_b,
               in_ready_a, in_ready_b, in_alu_val_hw, in_set_CC, in_cond, in_nzcv, in_nzcv_tag,
               in_nzcv_ready, in_dst_tag, in_cdb_valid, in_cdb_tag, in_cdb_value,
               in_cdb_set_nzcv, in_cdb_nzcv, in_fu_ready,
        input  out_dispatch_ready, out_issue_valid, out_alu_op, out_val_a, out_val_b,
               out_alu_val_hw, out_set_CC, out_cond, out_prev_nzcv, out_dst_tag
    );

    modport slave (
        input  in_flush, in_dispatch_valid, in_alu_op, in_val_a, in_val_b, in_tag_a, in_tag_b,
               in_ready_a, in_ready_b, in_alu_val_hw, in_set_CC, in_cond, in_nzcv, in_nzcv_tag,
               in_nzcv_ready, in_dst_tag, in_cdb_valid, in_cdb_tag, in_cdb_value,
               in_cdb_set_nzcv, in_cdb_nzcv, in_fu_ready,
        output out_dispatch_ready, out_issue_valid, out_alu_op, out_val_a, out_val_b,
               out_alu_val_hw, out_set_CC, out_cond, out_prev_nzcv, out_dst_tag
    );

endinterface

// File: rtl/rs_find_first.sv
// rtl/rs_find_first.sv - lowest-index set bit finder with valid flag
module rs_find_first #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) o_idx = IDX_W'(i);
        end
    end

    assign o_valid = |i_req;

endmodule

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - holds ALU micro-ops until operands arrive, issues one per cycle
module alu_reservation_station import alu_reservation_station_pkg::*; #(
    parameter int RS_ENTRIES = 4,
    parameter int TAG_W      = RS_TAG_W
) (
    input logic                     in_clk,
    input logic                     in_rst_n,
    alu_reservation_station_if.slave bus
);
    localparam int IDX_W = $clog2(RS_ENTRIES);

    rs_entry_t             r_ent      [RS_ENTRIES];
    rs_entry_t             w_ent_nxt  [RS_ENTRIES];
    rs_entry_t             w_disp_ent;
    logic [RS_ENTRIES-1:0] w_free;
    logic [RS_ENTRIES-1:0] w_ready;
    logic [IDX_W-1:0]      w_alloc_idx;
    logic [IDX_W-1:0]      w_sel_idx;
    logic                  w_alloc_valid;
    logic                  w_sel_valid;
    logic                  w_dispatch_ready;
    logic                  w_disp_en;
    logic                  w_issue_load;
    logic [TAG_W-1:0]      w_cdb_tag;
    logic                  w_cdb_nzcv_valid;

    logic                  r_alive;
    logic                  r_issue_valid;
    alu_op_t               r_iss_op;
    logic [GPR_SIZE-1:0]   r_iss_val_a;
    logic [GPR_SIZE-1:0]   r_iss_val_b;
    logic [5:0]            r_iss_hw;
    logic                  r_iss_set_cc;
    cond_t                 r_iss_cond;
    nzcv_t                 r_iss_nzcv;
    rs_tag_t               r_iss_dst;

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_free[i]  = (r_ent[i].state == RS_FREE);
            w_ready[i] = (r_ent[i].state == RS_READY);
        end
    end

    rs_find_first #(.N(RS_ENTRIES)) u_alloc (.i_req(w_free),  .o_idx(w_alloc_idx), .o_valid(w_alloc_valid));
    rs_find_first #(.N(RS_ENTRIES)) u_select(.i_req(w_ready), .o_idx(w_sel_idx),   .o_valid(w_sel_valid));

    // r_alive keeps dispatch closed until the first clock after reset release.
    assign w_dispatch_ready = r_alive & w_alloc_valid;
    assign w_disp_en        = bus.in_dispatch_valid & w_dispatch_ready;
    assign w_issue_load     = w_sel_valid & (~r_issue_valid | bus.in_fu_ready);
    assign w_cdb_tag        = bus.in_cdb_tag;
    assign w_cdb_nzcv_valid = bus.in_cdb_valid & bus.in_cdb_set_nzcv;

    always_comb begin
        w_disp_ent          = '0;
        w_disp_ent.op       = bus.in_alu_op;
        w_disp_ent.val_hw   = bus.in_alu_val_hw;
        w_disp_ent.set_cc   = bus.in_set_CC;
        w_disp_ent.cond     = bus.in_cond;
        w_disp_ent.dst_tag  = bus.in_dst_tag;
        w_disp_ent.tag_a    = bus.in_tag_a;
        w_disp_ent.tag_b    = bus.in_tag_b;
        w_disp_ent.nzcv_tag = bus.in_nzcv_tag;
        w_disp_ent.rdy_a    = bus.in_ready_a | cdb_hit(bus.in_cdb_valid, bus.in_ready_a, bus.in_tag_a, w_cdb_tag);
        w_disp_ent.rdy_b    = bus.in_ready_b | cdb_hit(bus.in_cdb_valid, bus.in_ready_b, bus.in_tag_b, w_cdb_tag);
        w_disp_ent.nzcv_rdy = bus.in_nzcv_ready
                            | cdb_hit(w_cdb_nzcv_valid, bus.in_nzcv_ready, bus.in_nzcv_tag, w_cdb_tag);
        w_disp_ent.val_a    = bus.in_ready_a ? bus.in_val_a : bus.in_cdb_value;
        w_disp_ent.val_b    = bus.in_ready_b ? bus.in_val_b : bus.in_cdb_value;
        w_disp_ent.nzcv     = bus.in_nzcv_ready ? bus.in_nzcv : bus.in_cdb_nzcv;
        w_disp_ent.state    = (w_disp_ent.rdy_a & w_disp_ent.rdy_b & w_disp_ent.nzcv_rdy) ? RS_READY : RS_WAIT;
    end

    always_comb begin
        for (int i = 0; i < RS_ENTRIES; i++) begin
            w_ent_nxt[i] = r_ent[i];
            if (r_ent[i].state == RS_WAIT) begin
                if (cdb_hit(bus.in_cdb_valid, r_ent[i].rdy_a, r_ent[i].tag_a, w_cdb_tag)) begin
                    w_ent_nxt[i].val_a = bus.in_cdb_value;
                    w_ent_nxt[i].rdy_a = 1'b1;
                end
                if (cdb_hit(bus.in_cdb_valid, r_ent[i].rdy_b, r_ent[i].tag_b, w_cdb_tag)) begin
                    w_ent_nxt[i].val_b = bus.in_cdb_value;
                    w_ent_nxt[i].rdy_b = 1'b1;
                end
                if (cdb_hit(w_cdb_nzcv_valid, r_ent[i].nzcv_rdy, r_ent[i].nzcv_tag, w_cdb_tag)) begin
                    w_ent_nxt[i].nzcv     = bus.in_cdb_nzcv;
                    w_ent_nxt[i].nzcv_rdy = 1'b1;
                end
                if (w_ent_nxt[i].rdy_a & w_ent_nxt[i].rdy_b & w_ent_nxt[i].nzcv_rdy)
                    w_ent_nxt[i].state = RS_READY;
            end
            if (w_issue_load && (IDX_W'(i) == w_sel_idx))
                w_ent_nxt[i].state = RS_FREE;
            if (w_disp_en && (IDX_W'(i) == w_alloc_idx))
                w_ent_nxt[i] = w_disp_ent;
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < RS_ENTRIES; i++) r_ent[i] <= '0;
            r_alive       <= 1'b0;
            r_issue_valid <= 1'b0;
            r_iss_op      <= ALU_OP_PLUS;
            r_iss_val_a   <= '0;
            r_iss_val_b   <= '0;
            r_iss_hw      <= '0;
            r_iss_set_cc  <= 1'b0;
            r_iss_cond    <= COND_EQ;
            r_iss_nzcv    <= '0;
            r_iss_dst     <= '0;
        end else if (bus.in_flush) begin
            for (int i = 0; i < RS_ENTRIES; i++) r_ent[i].state <= RS_FREE;
            r_alive       <= 1'b1;
            r_issue_valid <= 1'b0;
        end else begin
            for (int i = 0; i < RS_ENTRIES; i++) r_ent[i] <= w_ent_nxt[i];
            r_alive <= 1'b1;
            if (w_issue_load) begin
                r_issue_valid <= 1'b1;
                r_iss_op      <= r_ent[w_sel_idx].op;
                r_iss_val_a   <= r_ent[w_sel_idx].val_a;
                r_iss_val_b   <= r_ent[w_sel_idx].val_b;
                r_iss_hw      <= r_ent[w_sel_idx].val_hw;
                r_iss_set_cc  <= r_ent[w_sel_idx].set_cc;
                r_iss_cond    <= r_ent[w_sel_idx].cond;
                r_iss_nzcv    <= r_ent[w_sel_idx].nzcv;
                r_iss_dst     <= r_ent[w_sel_idx].dst_tag;
            end else if (bus.in_fu_ready) begin
                r_issue_valid <= 1'b0;
            end
        end
    end

    assign bus.out_dispatch_ready = w_dispatch_ready;
    assign bus.out_issue_valid    = r_issue_valid;
    assign bus.out_alu_op         = r_iss_op;
    assign bus.out_val_a          = r_iss_val_a;
    assign bus.out_val_b          = r_iss_val_b;
    assign bus.out_alu_val_hw     = r_iss_hw;
    assign bus.out_set_CC         = r_iss_set_cc;
    assign bus.out_cond           = r_iss_cond;
    assign bus.out_prev_nzcv      = r_iss_nzcv;
    assign bus.out_dst_tag        = r_iss_dst;

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - scoreboard bench for alu_reservation_station
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic in_clk   = 1'b0;
    logic in_rst_n = 1'b0;
    always #5 in_clk = ~in_clk;

    alu_reservation_station_if #(.TAG_W(RS_TAG_W)) bus();

    alu_reservation_station #(.RS_ENTRIES(4), .TAG_W(RS_TAG_W)) dut (
        .in_clk   (in_clk),
        .in_rst_n (in_rst_n),
        .bus      (bus.slave)
    );

    typedef struct packed {
        alu_op_t     op;
        logic [63:0] a;
        logic [63:0] b;
        nzcv_t       nzcv;
        rs_tag_t     dst;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge in_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        bus.in_flush = 0; bus.in_dispatch_valid = 0; bus.in_alu_op = ALU_OP_PLUS;
        bus.in_val_a = '0; bus.in_val_b = '0; bus.in_tag_a = '0; bus.in_tag_b = '0;
        bus.in_ready_a = 0; bus.in_ready_b = 0; bus.in_alu_val_hw = '0; bus.in_set_CC = 0;
        bus.in_cond = COND_EQ; bus.in_nzcv = '0; bus.in_nzcv_tag = '0; bus.in_nzcv_ready = 0;
        bus.in_dst_tag = '0; bus.in_cdb_valid = 0; bus.in_cdb_tag = '0; bus.in_cdb_value = '0;
        bus.in_cdb_set_nzcv = 0; bus.in_cdb_nzcv = '0; bus.in_fu_ready = 0;
    endtask

    task automatic expect_issue(input alu_op_t op, input logic [63:0] a, input logic [63:0] b,
                                input nzcv_t nz, input rs_tag_t dst);
        sb_q.push_back('{op: op, a: a, b: b, nzcv: nz, dst: dst});
    endtask

    task automatic dispatch(input alu_op_t op, input logic [63:0] a, input logic ra, input rs_tag_t ta,
                            input logic [63:0] b, input logic rb, input rs_tag_t tb_tag,
                            input nzcv_t nz, input logic nrdy, input rs_tag_t ntag, input rs_tag_t dst);
        int budget = 0;
        while (!bus.out_dispatch_ready && budget < 20) begin
            step(1);
            budget++;
        end
        check("dispatch_ready_wait", 64'(bus.out_dispatch_ready), 64'd1);
        bus.in_alu_op = op; bus.in_val_a = a; bus.in_ready_a = ra; bus.in_tag_a = ta;
        bus.in_val_b = b; bus.in_ready_b = rb; bus.in_tag_b = tb_tag;
        bus.in_nzcv = nz; bus.in_nzcv_ready = nrdy; bus.in_nzcv_tag = ntag;
        bus.in_dst_tag = dst; bus.in_alu_val_hw = {2'b00, dst}; bus.in_set_CC = 1; bus.in_cond = COND_NE;
        bus.in_dispatch_valid = 1;
        step(1);
        bus.in_dispatch_valid = 0;
    endtask

    task automatic cdb_drive(input rs_tag_t tag, input logic [63:0] v, input logic setn, input nzcv_t nz);
        bus.in_cdb_valid = 1; bus.in_cdb_tag = tag; bus.in_cdb_value = v;
        bus.in_cdb_set_nzcv = setn; bus.in_cdb_nzcv = nz;
    endtask

    task automatic cdb_clear();
        bus.in_cdb_valid = 0; bus.in_cdb_set_nzcv = 0;
    endtask

    // Every op the ALU accepts must match the oldest outstanding expectation.
    always @(negedge in_clk) begin
        if (in_rst_n && bus.out_issue_valid && bus.in_fu_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_issue_valid", 64'(bus.out_issue_valid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("iss_op",    64'(bus.out_alu_op),     64'(mon_e.op));
                check("iss_val_a", bus.out_val_a,           mon_e.a);
                check("iss_val_b", bus.out_val_b,           mon_e.b);
                check("iss_nzcv",  64'(bus.out_prev_nzcv),  64'(mon_e.nzcv));
                check("iss_dst",   64'(bus.out_dst_tag),    64'(mon_e.dst));
                check("iss_hw",    64'(bus.out_alu_val_hw), 64'({2'b00, mon_e.dst}));
                check("iss_cond",  64'(bus.out_cond),       64'(COND_NE));
                check("iss_setcc", 64'(bus.out_set_CC),     64'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        idle_inputs();
        #12;
        check("rst_issue_valid",    64'(bus.out_issue_valid),    64'd0);
        check("rst_dispatch_ready", 64'(bus.out_dispatch_ready), 64'd0);
        check("rst_val_a",          bus.out_val_a,               64'd0);
        check("rst_dst_tag",        64'(bus.out_dst_tag),        64'd0);
        @(negedge in_clk);
        in_rst_n = 1;
        step(1);
        check("post_rst_dispatch_ready", 64'(bus.out_dispatch_ready), 64'd1);

        // Fully ready ADD: visible two edges after dispatch begins.
        bus.in_fu_ready = 1;
        expect_issue(ALU_OP_PLUS, 64'd5, 64'd7, 4'd0, 4'd1);
        dispatch(ALU_OP_PLUS, 64'd5, 1, 4'd0, 64'd7, 1, 4'd0, 4'd0, 1, 4'd0, 4'd1);
        check("t1_not_yet", 64'(bus.out_issue_valid), 64'd0);
        step(1);
        check("t1_issue",   64'(bus.out_issue_valid), 64'd1);
        check("t1_val_a",   bus.out_val_a, 64'd5);
        step(1);
        check("t1_drop",    64'(bus.out_issue_valid), 64'd0);

        // SUB waiting on tag 3, woken by a CDB broadcast.
        expect_issue(ALU_OP_MINUS, 64'h10, 64'd2, 4'd0, 4'd2);
        dispatch(ALU_OP_MINUS, 64'd0, 0, 4'd3, 64'd2, 1, 4'd0, 4'd0, 1, 4'd0, 4'd2);
        step(2);
        check("t2_waiting", 64'(bus.out_issue_valid), 64'd0);
        cdb_drive(4'd3, 64'h10, 0, 4'd0);
        step(1);
        cdb_clear();
        check("t2_no_same_cycle", 64'(bus.out_issue_valid), 64'd0);
        step(1);
        check("t2_issue", 64'(bus.out_issue_valid), 64'd1);
        check("t2_val_a", bus.out_val_a, 64'h10);
        step(1);

        // Same-cycle CDB bypass at dispatch.
        expect_issue(ALU_OP_MINUS, 64'h22, 64'd3, 4'd0, 4'd3);
        cdb_drive(4'd3, 64'h22, 0, 4'd0);
        dispatch(ALU_OP_MINUS, 64'd0, 0, 4'd3, 64'd3, 1, 4'd0, 4'd0, 1, 4'd0, 4'd3);
        cdb_clear();
        check("t2b_not_yet", 64'(bus.out_issue_valid), 64'd0);
        step(1);
        check("t2b_issue", 64'(bus.out_issue_valid), 64'd1);
        check("t2b_val_a", bus.out_val_a, 64'h22);
        step(1);

        // CSEL waits for flags from tag 5; a flagless broadcast must not wake it.
        expect_issue(ALU_OP_CSEL, 64'hA, 64'hB, 4'b0100, 4'd4);
        dispatch(ALU_OP_CSEL, 64'hA, 1, 4'd0, 64'hB, 1, 4'd0, 4'd0, 0, 4'd5, 4'd4);
        step(1);
        cdb_drive(4'd5, 64'h55, 0, 4'b1111);
        step(1);
        cdb_clear();
        step(2);
        check("t3_flagless_cdb", 64'(bus.out_issue_valid), 64'd0);
        cdb_drive(4'd5, 64'h66, 1, 4'b0100);
        step(1);
        cdb_clear();
        step(1);
        check("t3_issue", 64'(bus.out_issue_valid), 64'd1);
        check("t3_nzcv",  64'(bus.out_prev_nzcv), 64'b0100);
        step(1);

        // Stall downstream, fill every entry behind a held issue register.
        bus.in_fu_ready = 0;
        expect_issue(ALU_OP_PLUS, 64'h100, 64'h200, 4'd0, 4'd5);
        dispatch(ALU_OP_PLUS, 64'h100, 1, 4'd0, 64'h200, 1, 4'd0, 4'd0, 1, 4'd0, 4'd5);
        step(1);
        check("t4_reg_loaded", 64'(bus.out_dst_tag), 64'd5);
        for (int k = 1; k <= 4; k++) begin
            expect_issue(ALU_OP_EOR, 64'h100 + 64'(k), 64'h200, 4'd0, rs_tag_t'(5 + k));
            dispatch(ALU_OP_EOR, 64'h100 + 64'(k), 1, 4'd0, 64'h200, 1, 4'd0, 4'd0, 1, 4'd0, rs_tag_t'(5 + k));
        end
        check("t4_full", 64'(bus.out_dispatch_ready), 64'd0);
        bus.in_dst_tag = 4'd15; bus.in_dispatch_valid = 1;
        step(1);
        bus.in_dispatch_valid = 0;
        check("t4_still_full", 64'(bus.out_dispatch_ready), 64'd0);
        check("t4_held_dst",   64'(bus.out_dst_tag), 64'd5);
        check("t4_held_val_a", bus.out_val_a, 64'h100);
        bus.in_fu_ready = 1;
        step(1);
        check("t4_entry0_first", 64'(bus.out_dst_tag), 64'd6);
        check("t4_ready_back",   64'(bus.out_dispatch_ready), 64'd1);
        step(4);
        check("t4_drained", 64'(bus.out_issue_valid), 64'd0);

        // Flush with a valid issue register and three waiting entries.
        bus.in_fu_ready = 0;
        dispatch(ALU_OP_AND, 64'd1, 1, 4'd0, 64'd1, 1, 4'd0, 4'd0, 1, 4'd0, 4'd9);
        for (int k = 0; k < 3; k++)
            dispatch(ALU_OP_ORR, 64'd0, 0, rs_tag_t'(6 + k), 64'd1, 1, 4'd0, 4'd0, 1, 4'd0, rs_tag_t'(10 + k));
        check("t5_pre_valid", 64'(bus.out_issue_valid), 64'd1);
        bus.in_flush = 1;
        step(1);
        bus.in_flush = 0;
        check("t5_flush_valid", 64'(bus.out_issue_valid), 64'd0);
        check("t5_flush_ready", 64'(bus.out_dispatch_ready), 64'd1);
        bus.in_fu_ready = 1;
        for (int k = 0; k < 3; k++) begin
            cdb_drive(rs_tag_t'(6 + k), 64'h77, 0, 4'd0);
            step(1);
        end
        cdb_clear();
        step(3);
        check("t5_no_ghost", 64'(bus.out_issue_valid), 64'd0);

        // Asynchronous reset in the middle of a stall.
        bus.in_fu_ready = 0;
        dispatch(ALU_OP_PLUS, 64'h33, 1, 4'd0, 64'h44, 1, 4'd0, 4'd0, 1, 4'd0, 4'd13);
        dispatch(ALU_OP_PLUS, 64'h35, 1, 4'd0, 64'h46, 1, 4'd0, 4'd0, 1, 4'd0, 4'd14);
        step(1);
        check("t6_pre_valid", 64'(bus.out_issue_valid), 64'd1);
        @(negedge in_clk);
        #2;
        in_rst_n = 0;
        #1;
        check("t6_rst_valid",  64'(bus.out_issue_valid),    64'd0);
        check("t6_rst_ready",  64'(bus.out_dispatch_ready), 64'd0);
        check("t6_rst_val_a",  bus.out_val_a,               64'd0);
        check("t6_rst_dst",    64'(bus.out_dst_tag),        64'd0);
        check("t6_rst_op",     64'(bus.out_alu_op),         64'd0);
        #1;
        in_rst_n = 1;
        step(1);
        check("t6_ready_after", 64'(bus.out_dispatch_ready), 64'd1);
        bus.in_fu_ready = 1;
        expect_issue(ALU_OP_PLUS, 64'h1234, 64'd1, 4'd0, 4'd7);
        dispatch(ALU_OP_PLUS, 64'h1234, 1, 4'd0, 64'd1, 1, 4'd0, 4'd0, 1, 4'd0, 4'd7);
        step(1);
        check("t6_resume", 64'(bus.out_issue_valid), 64'd1);
        step(2);

        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
